// File: rtl/mem_bist_ctrl.sv
// Memory BIST sequencer: writes a seeded address pattern to every word, reads it back,
// counts mismatches (saturating) and latches the first failing address.
module mem_bist_ctrl #(
  parameter int unsigned WID_MEM   = 64,
  parameter int unsigned DEPTH_MEM = 512,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned ERR_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [WID_MEM-1:0] seed,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_count,
  output logic [ADDR_W-1:0]  first_err_addr,
  output logic [ADDR_W-1:0]  mem_raddr,
  output logic [ADDR_W-1:0]  mem_waddr,
  output logic [WID_MEM-1:0] mem_din,
  output logic               mem_we,
  input  logic [WID_MEM-1:0] mem_dout
);

  typedef enum logic [2:0] {StIdle, StWrite, StRead, StDrain, StDone} state_e;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH_MEM - 1);

  function automatic logic [WID_MEM-1:0] pat(input logic [WID_MEM-1:0] s,
                                             input logic [ADDR_W-1:0]  a);
    return s ^ WID_MEM'(a);
  endfunction

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [WID_MEM-1:0]   seed_q, seed_d;
  logic                 mode_q, mode_d;
  logic                 cmp_v_q, cmp_v_d;
  logic [ADDR_W-1:0]    cmp_a_q, cmp_a_d;
  logic [ERR_W-1:0]     err_q, err_d;
  logic [ADDR_W-1:0]    first_q, first_d;

  logic                 busy_q, done_q, pass_q, mem_we_q;
  logic [ADDR_W-1:0]    mem_raddr_q, mem_waddr_q;
  logic [WID_MEM-1:0]   mem_din_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    seed_d  = seed_q;
    mode_d  = mode_q;
    cmp_v_d = 1'b0;
    cmp_a_d = cmp_a_q;
    err_d   = err_q;
    first_d = first_q;

    // Readback for cmp_a_q arrives this cycle; err_q==0 means no error seen since start.
    if (cmp_v_q && (mem_dout != pat(seed_q, cmp_a_q))) begin
      if (err_q == '0) first_d = cmp_a_q;
      if (err_q != '1) err_d = err_q + ERR_W'(1);
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          seed_d  = seed;
          mode_d  = mode;
          addr_d  = '0;
          err_d   = '0;
          first_d = '0;
          state_d = mode ? StRead : StWrite;
        end
      end
      StWrite: begin
        if (addr_q == LastAddr) begin
          addr_d  = '0;
          state_d = StRead;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      StRead: begin
        cmp_v_d = 1'b1;
        cmp_a_d = addr_q;
        if (addr_q == LastAddr) state_d = StDrain;
        else                    addr_d  = addr_q + ADDR_W'(1);
      end
      StDrain: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      seed_q      <= '0;
      mode_q      <= 1'b0;
      cmp_v_q     <= 1'b0;
      cmp_a_q     <= '0;
      err_q       <= '0;
      first_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_raddr_q <= '0;
      mem_waddr_q <= '0;
      mem_din_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      seed_q      <= seed_d;
      mode_q      <= mode_d;
      cmp_v_q     <= cmp_v_d;
      cmp_a_q     <= cmp_a_d;
      err_q       <= err_d;
      first_q     <= first_d;
      busy_q      <= state_d inside {StWrite, StRead, StDrain};
      done_q      <= (state_d == StDone);
      pass_q      <= (state_d == StDone) && (err_d == '0);
      mem_we_q    <= (state_d == StWrite) && !mode_d;
      mem_raddr_q <= addr_d;
      mem_waddr_q <= addr_d;
      mem_din_q   <= (state_d == StWrite) ? pat(seed_d, addr_d) : '0;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;
  assign mem_raddr      = mem_raddr_q;
  assign mem_waddr      = mem_waddr_q;
  assign mem_din        = mem_din_q;
  assign mem_we         = mem_we_q;

endmodule
